// File: rtl/count_bcd_pkg.sv
// Shared definitions for the count_bcd_conv binary-to-BCD converter.
// Holds the FSM state enum, the default sizing constants and a helper
// that gives the minimum digit count for a given signed input width.
package count_bcd_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DIGITS = 10;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    // Decimal digits needed for 2^(width-1), the largest magnitude a
    // WIDTH-bit two's complement value can produce.
    // Uses floor(n * log10(2)) + 1 with log10(2) ~ 0.30103.
    function automatic int min_digits(input int width);
        return ((width - 1) * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Single-digit double-dabble correction: a digit of 5 or more gets 3
// added so that the following left shift carries correctly into the
// next decimal digit.
module bcd_add3_digit
    import count_bcd_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    // Add 3 when the digit would reach 10 or more after doubling.
    always_comb begin
        d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;
    end

endmodule

// File: rtl/count_bcd_conv.sv
// Sequential binary-to-BCD converter for the up/down counter's signed
// count. Converts the magnitude one bit per clock (shift-add-3) and
// reports sign and packed BCD digits with a start/busy/done handshake.
// Handshake: start is sampled only while IDLE; busy is high for the
// WIDTH cycles of a conversion; done pulses for one cycle when bcd/neg
// (and blank) take the new result; busy and done never overlap.
// Optional macro COUNT_BCD_BLANK_EN adds the registered leading-zero
// blank mask output.
module count_bcd_conv
    import count_bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  dbg_state
`ifdef COUNT_BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    // Refuse to build a converter that cannot hold the largest magnitude.
    if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
        $error("count_bcd_conv: DIGITS too small for WIDTH");
    end

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]      mag_q, mag_d;
    logic [4*DIGITS-1:0]   scr_q, scr_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  sign_q, sign_d;
    logic                  neg_q, neg_d;
    logic                  done_q, done_d;

    logic [4*DIGITS-1:0]   corr;
    logic [4*DIGITS-1:0]   scr_shift;
    logic                  unused_top_msb;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .d_i (scr_q[4*g +: 4]),
            .d_o (corr[4*g +: 4])
        );
    end

    // The corrected scratch shifted left with the next magnitude bit.
    // The top digit's MSB is always clear when DIGITS is large enough.
    assign scr_shift      = {corr[4*DIGITS-2:0], mag_q[WIDTH-1]};
    assign unused_top_msb = corr[4*DIGITS-1];

`ifdef COUNT_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d, blank_next;

    // Mark each digit that has only zeros at and above it; digit 0 always shows.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_next = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above    = zero_above & (scr_shift[4*i +: 4] == 4'd0);
            blank_next[i] = zero_above;
        end
        blank_next[0] = 1'b0;
    end
`endif

    // Next-state and datapath control for the IDLE/CONV sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        sign_d  = sign_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
`ifdef COUNT_BCD_BLANK_EN
        blank_d = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = value[WIDTH-1];
                    // Negating -2^(WIDTH-1) gives 2^(WIDTH-1) as unsigned.
                    mag_d   = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;
                    scr_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = CONV;
                end
            end
            CONV: begin
                scr_d = scr_shift;
                mag_d = {mag_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = scr_shift;
                    neg_d   = sign_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef COUNT_BCD_BLANK_EN
                    blank_d = blank_next;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset discards any partial conversion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mag_q   <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef COUNT_BCD_BLANK_EN
            blank_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            sign_q  <= sign_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
`ifdef COUNT_BCD_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign busy      = (state_q == CONV);
    assign done      = done_q;
    assign neg       = neg_q;
    assign bcd       = bcd_q;
    assign dbg_state = state_q;
`ifdef COUNT_BCD_BLANK_EN
    assign blank     = blank_q;
`endif

endmodule

// File: tb/tb_count_bcd_conv.sv
// Directed testbench for count_bcd_conv with hand-computed BCD results.
module tb_count_bcd_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] value = '0;
    logic        busy, done, neg, dbg_state;
    logic [39:0] bcd;
`ifdef COUNT_BCD_BLANK_EN
    logic [9:0]  blank;
`endif

    int n_cmp = 0;
    int n_err = 0;

    count_bcd_conv dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .value     (value),
        .busy      (busy),
        .done      (done),
        .neg       (neg),
        .bcd       (bcd),
        .dbg_state (dbg_state)
`ifdef COUNT_BCD_BLANK_EN
        ,
        .blank     (blank)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One conversion: start pulse, busy every cycle until done, result,
    // done is a single-cycle pulse, result holds afterwards.
    task automatic run_conv(input logic [31:0] v, input logic [39:0] exp_bcd,
                            input logic exp_neg, input string tag);
        int   n;
        logic busy_ok;
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        value = $urandom;
        n = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            if (!(busy === 1'b1 && done === 1'b0)) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd32);
        check({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_bcd"}, 64'(bcd), 64'(exp_bcd));
        check({tag, "_neg"}, 64'(neg), 64'(exp_neg));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_bcd_hold"}, 64'(bcd), 64'(exp_bcd));
    endtask

    initial begin
        int n;

        // Reset
        value = 32'd50;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_neg", 64'(neg), 64'd0);
        check("rst_bcd", 64'(bcd), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        rst = 1'b1;

        // Main function
        run_conv(32'd50, 40'h0000000050, 1'b0, "v50");
`ifdef COUNT_BCD_BLANK_EN
        check("v50_blank", 64'(blank), 64'b1111111100);
`endif
        run_conv(32'hFFFF_FFFF, 40'h0000000001, 1'b1, "vm1");
        run_conv(32'd0, 40'h0000000000, 1'b0, "v0");
`ifdef COUNT_BCD_BLANK_EN
        check("v0_blank", 64'(blank), 64'b1111111110);
`endif
        run_conv(32'h7FFF_FFFF, 40'h2147483647, 1'b0, "vmax");
        run_conv(32'h8000_0000, 40'h2147483648, 1'b1, "vmin");

        // Asynchronous reset mid-conversion
        @(negedge clk);
        value = 32'd999999;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("midrst_busy_before", 64'(busy), 64'd1);
        check("midrst_state_before", 64'(dbg_state), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_bcd", 64'(bcd), 64'd0);
        check("midrst_neg", 64'(neg), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_conv(32'd123, 40'h0000000123, 1'b0, "v123");

        // start held high; value changes mid-conversion; back-to-back accept
        @(negedge clk);
        value = 32'd49;
        start = 1'b1;
        repeat (10) @(negedge clk);
        value = 32'd7;
        n = 9;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("hold_latency", 64'(n), 64'd32);
        check("hold_bcd", 64'(bcd), 64'h49);
        check("hold_neg", 64'(neg), 64'd0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_done_low", 64'(done), 64'd0);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_latency", 64'(n), 64'd32);
        check("b2b_bcd", 64'(bcd), 64'h7);
        @(negedge clk);
        check("b2b_no_queue", 64'(busy), 64'd0);
        check("b2b_done_pulse", 64'(done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
